// File: rtl/tc_irq_bridge.sv
// Bridge between the CPU data port, two timer/counters and an external interrupt line.
// Build with IRQ_BRIDGE_RR_EN defined to get round-robin instead of fixed-priority arbitration.
module tc_irq_bridge #(
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
    parameter logic [31:0] IC_BASE  = 32'h0000_7F20
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [29:0] cpu_addr_i,
    input  logic        cpu_we_i,
    input  logic        cpu_re_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic [29:0] tc0_addr_o,
    output logic [29:0] tc1_addr_o,
    output logic        tc0_we_o,
    output logic        tc1_we_o,
    output logic [31:0] tc0_din_o,
    output logic [31:0] tc1_din_o,
    input  logic [31:0] tc0_dout_i,
    input  logic [31:0] tc1_dout_i,
    input  logic        tc0_irq_i,
    input  logic        tc1_irq_i,
    input  logic        ext_irq_i,
    output logic        irq_out_o,
    output logic [1:0]  irq_id_o
);

    localparam logic [29:0] TC0_WBASE = TC0_BASE[31:2];
    localparam logic [29:0] TC1_WBASE = TC1_BASE[31:2];
    localparam logic [29:0] IC_WBASE  = IC_BASE[31:2];

    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [2:0]  pend_q, pend_d;
    logic [2:0]  mask_q, mask_d;
    logic [2:0]  prev_q;
    logic [2:0]  src, rise, cand, pend_clr;
    logic [1:0]  win_id;
    logic [29:0] tc0_off, tc1_off, ic_off;
    logic        hit0, hit1, hit_ic;
    logic        claim_hit, complete_hit;
`ifdef IRQ_BRIDGE_RR_EN
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  idx;
`endif

    // Unsigned wrap-around makes "offset < size" a full window check.
    assign tc0_off = cpu_addr_i - TC0_WBASE;
    assign tc1_off = cpu_addr_i - TC1_WBASE;
    assign ic_off  = cpu_addr_i - IC_WBASE;
    assign hit0    = tc0_off < 30'd3;
    assign hit1    = tc1_off < 30'd3;
    assign hit_ic  = ic_off < 30'd4;

    assign tc0_addr_o = tc0_off;
    assign tc1_addr_o = tc1_off;
    assign tc0_we_o   = cpu_we_i & hit0;
    assign tc1_we_o   = cpu_we_i & hit1;
    assign tc0_din_o  = cpu_wdata_i;
    assign tc1_din_o  = cpu_wdata_i;

    assign claim_hit    = cpu_re_i & hit_ic & (ic_off[1:0] == 2'd2);
    assign complete_hit = cpu_we_i & hit_ic & (ic_off[1:0] == 2'd3);

    assign src  = {ext_irq_i, tc1_irq_i, tc0_irq_i};
    assign rise = src & ~prev_q;
    assign cand = pend_q & mask_q;

    always_comb begin
        win_id = 2'd3;
`ifdef IRQ_BRIDGE_RR_EN
        idx = 2'd0;
        // Walk the sources from the pointer; the last hit written is the nearest one.
        for (int k = 2; k >= 0; k--) begin
            idx = 2'((int'(ptr_q) + k) % 3);
            if (cand[idx]) win_id = idx;
        end
`else
        if (cand[2]) win_id = 2'd2;
        if (cand[1]) win_id = 2'd1;
        if (cand[0]) win_id = 2'd0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        pend_clr = 3'b000;
`ifdef IRQ_BRIDGE_RR_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d = REQ;
                    sel_d   = win_id;
                end
            end
            REQ: begin
                if (claim_hit) begin
                    state_d  = SERV;
                    pend_clr = 3'b001 << sel_q;
`ifdef IRQ_BRIDGE_RR_EN
                    ptr_d    = (sel_q == 2'd2) ? 2'd0 : 2'(sel_q + 2'd1);
`endif
                end else if (cand == 3'b000) begin
                    state_d = IDLE;
                end else begin
`ifdef IRQ_BRIDGE_RR_EN
                    if (!cand[sel_q]) sel_d = win_id;
`else
                    sel_d = win_id;
`endif
                end
            end
            SERV: begin
                if (complete_hit && (cpu_wdata_i[1:0] == sel_q)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A rising edge in the same cycle as a claim keeps the bit set.
    assign pend_d = (pend_q & ~pend_clr) | rise;
    assign mask_d = (cpu_we_i && hit_ic && ic_off[1:0] == 2'd1) ? cpu_wdata_i[2:0] : mask_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            pend_q  <= 3'b000;
            mask_q  <= 3'b000;
            prev_q  <= 3'b000;
`ifdef IRQ_BRIDGE_RR_EN
            ptr_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            prev_q  <= src;
`ifdef IRQ_BRIDGE_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign irq_out_o = (state_q == REQ);
    assign irq_id_o  = (state_q == REQ) ? sel_q : 2'd3;

    always_comb begin
        cpu_rdata_o = 32'h0;
        if (hit0) begin
            cpu_rdata_o = tc0_dout_i;
        end else if (hit1) begin
            cpu_rdata_o = tc1_dout_i;
        end else if (hit_ic) begin
            case (ic_off[1:0])
                2'd0:    cpu_rdata_o = {29'b0, pend_q};
                2'd1:    cpu_rdata_o = {29'b0, mask_q};
                2'd2:    cpu_rdata_o = (state_q == REQ) ? {30'b0, sel_q} : 32'h3;
                default: cpu_rdata_o = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_tc_irq_bridge.sv
// Directed self-checking bench for tc_irq_bridge; the round-robin order
// section only runs when IRQ_BRIDGE_RR_EN is defined.
module tb_tc_irq_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] cpu_addr;
    logic        cpu_we, cpu_re;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic [29:0] tc0_addr, tc1_addr;
    logic        tc0_we, tc1_we;
    logic [31:0] tc0_din, tc1_din;
    logic [31:0] tc0_dout = 32'h1234_0000;
    logic [31:0] tc1_dout = 32'hCAFE_0001;
    logic [2:0]  src;
    logic        irq_out;
    logic [1:0]  irq_id;
    int          checkCount = 0;
    int          passCount  = 0;

    localparam logic [31:0] PEND_A = 32'h7F20, MASK_A = 32'h7F24;
    localparam logic [31:0] CLAIM_A = 32'h7F28, COMPL_A = 32'h7F2C;

    tc_irq_bridge dut (
        .clk_i(clk), .reset_i(reset),
        .cpu_addr_i(cpu_addr), .cpu_we_i(cpu_we), .cpu_re_i(cpu_re),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
        .tc0_addr_o(tc0_addr), .tc1_addr_o(tc1_addr),
        .tc0_we_o(tc0_we), .tc1_we_o(tc1_we),
        .tc0_din_o(tc0_din), .tc1_din_o(tc1_din),
        .tc0_dout_i(tc0_dout), .tc1_dout_i(tc1_dout),
        .tc0_irq_i(src[0]), .tc1_irq_i(src[1]), .ext_irq_i(src[2]),
        .irq_out_o(irq_out), .irq_id_o(irq_id)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [31:0] byteAddr, input logic we, input logic re,
                                 input logic [31:0] wdata);
        cpu_addr  = byteAddr[31:2];
        cpu_we    = we;
        cpu_re    = re;
        cpu_wdata = wdata;
    endtask

    task automatic busWrite(input logic [31:0] byteAddr, input logic [31:0] wdata);
        applyStimulus(byteAddr, 1'b1, 1'b0, wdata);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic readCheck(input logic [31:0] byteAddr, input logic [31:0] exp, input string tag);
        applyStimulus(byteAddr, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput(tag, cpu_rdata, exp);
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic claimRead(input logic [31:0] exp, input string tag);
        applyStimulus(CLAIM_A, 1'b0, 1'b1, 32'h0);
        #1;
        checkOutput(tag, cpu_rdata, exp);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic checkIrq(input logic expOut, input logic [1:0] expId, input string tag);
        checkOutput({tag, "_out"}, {31'b0, irq_out}, {31'b0, expOut});
        checkOutput({tag, "_id"}, {30'b0, irq_id}, {30'b0, expId});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [1:0] expPre;
        logic [1:0] rrOrder [4];
        rrOrder = '{2'd0, 2'd1, 2'd2, 2'd0};
        src = 3'b000;
        reset = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        checkIrq(1'b0, 2'd3, "reset");
        readCheck(PEND_A, 32'h0, "reset_pend");
        readCheck(MASK_A, 32'h0, "reset_mask");

        // Address decode and write strobes.
        applyStimulus(32'h7F00, 1'b1, 1'b0, 32'h9);
        #1;
        checkOutput("tc0_we", {31'b0, tc0_we}, 32'h1);
        checkOutput("tc0_addr", {2'b0, tc0_addr}, 32'h0);
        checkOutput("tc1_we_off", {31'b0, tc1_we}, 32'h0);
        checkOutput("tc0_din", tc0_din, 32'h9);
        tick();
        applyStimulus(32'h7F0C, 1'b1, 1'b0, 32'h5);
        #1;
        checkOutput("gap_we0", {31'b0, tc0_we}, 32'h0);
        checkOutput("gap_we1", {31'b0, tc1_we}, 32'h0);
        checkOutput("gap_rdata", cpu_rdata, 32'h0);
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        readCheck(32'h7F14, 32'hCAFE_0001, "tc1_rdata");
        applyStimulus(32'h7F18, 1'b1, 1'b0, 32'h7);
        #1;
        checkOutput("tc1_we", {31'b0, tc1_we}, 32'h1);
        checkOutput("tc1_addr", {2'b0, tc1_addr}, 32'h2);
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        readCheck(32'h7F08, 32'h1234_0000, "tc0_rdata");

        // Single source, held high through service.
        busWrite(MASK_A, 32'h7);
        src[1] = 1'b1;
        tick();
        readCheck(PEND_A, 32'h2, "pend_tc1");
        checkIrq(1'b0, 2'd3, "one_cycle");
        tick();
        checkIrq(1'b1, 2'd1, "req_tc1");
        claimRead(32'h1, "claim_tc1");
        checkIrq(1'b0, 2'd3, "serv_tc1");
        tick();
        readCheck(PEND_A, 32'h0, "held_no_reset");
        busWrite(COMPL_A, 32'h1);
        tick();
        checkIrq(1'b0, 2'd3, "idle_after_c1");
        src[1] = 1'b0;
        tick();

        // Simultaneous edges, mismatched and matching COMPLETE.
        src = 3'b110;
        tick();
        tick();
        checkIrq(1'b1, 2'd1, "prio_1_over_2");
        claimRead(32'h1, "claim_1");
        checkIrq(1'b0, 2'd3, "serv_1");
        readCheck(PEND_A, 32'h4, "pend_ext_left");
        busWrite(COMPL_A, 32'h2);
        tick();
        checkIrq(1'b0, 2'd3, "wrong_complete");
        claimRead(32'h3, "claim_in_serv");
        busWrite(COMPL_A, 32'h1);
        checkIrq(1'b0, 2'd3, "turnaround_idle");
        tick();
        checkIrq(1'b1, 2'd2, "turnaround_req");
        claimRead(32'h2, "claim_2");
        busWrite(COMPL_A, 32'h2);
        src = 3'b000;
        tick();

        // Masking a pending source, and a request withdrawn by the mask.
        busWrite(MASK_A, 32'h0);
        src[0] = 1'b1;
        tick();
        tick();
        checkIrq(1'b0, 2'd3, "masked");
        readCheck(PEND_A, 32'h1, "pend_masked");
        busWrite(MASK_A, 32'h1);
        tick();
        checkIrq(1'b1, 2'd0, "unmasked");
        busWrite(MASK_A, 32'h0);
        tick();
        checkIrq(1'b0, 2'd3, "withdrawn");
        busWrite(MASK_A, 32'h7);
        tick();
        checkIrq(1'b1, 2'd0, "re_req");
        claimRead(32'h0, "claim_0");

        // New edges during service, then reset mid-service.
        src[2] = 1'b1;
        tick();
        readCheck(PEND_A, 32'h4, "pend_in_serv");
        checkIrq(1'b0, 2'd3, "still_serv");
        reset = 1'b1;
        src = 3'b000;
        tick();
        reset = 1'b0;
        checkIrq(1'b0, 2'd3, "rst_serv");
        readCheck(PEND_A, 32'h0, "rst_pend");
        readCheck(MASK_A, 32'h0, "rst_mask");

        // A higher-priority edge while a request is outstanding.
        busWrite(MASK_A, 32'h7);
        src[2] = 1'b1;
        tick();
        tick();
        checkIrq(1'b1, 2'd2, "req_ext");
        src[0] = 1'b1;
        tick();
        checkIrq(1'b1, 2'd2, "pre_update");
        tick();
`ifdef IRQ_BRIDGE_RR_EN
        expPre = 2'd2;
`else
        expPre = 2'd0;
`endif
        checkIrq(1'b1, expPre, "preempt");
        claimRead({30'b0, expPre}, "claim_pre");

`ifdef IRQ_BRIDGE_RR_EN
        // Round-robin order with every source re-pulsed after service.
        reset = 1'b1;
        src = 3'b000;
        tick();
        reset = 1'b0;
        busWrite(MASK_A, 32'h7);
        src = 3'b111;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checkIrq(1'b1, rrOrder[i], "rr_req");
            claimRead({30'b0, rrOrder[i]}, "rr_claim");
            src[rrOrder[i]] = 1'b0;
            tick();
            src[rrOrder[i]] = 1'b1;
            tick();
            busWrite(COMPL_A, {30'b0, rrOrder[i]});
            tick();
        end
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
